// File: rtl/vector_ingest_pkg.sv
// vector_ingest_pkg: shared widths, packet type codes and FSM states for the ingest front-end
package vector_ingest_pkg;
    localparam int DEFAULT_DIM = 4;
    localparam int WORD_W = 32;
    localparam logic [7:0] DEFAULT_SYNC = 8'hA5;
    localparam logic [7:0] TYPE_VERTEX = 8'h01;
    localparam logic [7:0] TYPE_QUERY = 8'h02;
    typedef enum logic [2:0] {IDLE, TYPE, PAYLOAD, CHECK, EMIT} state_t;
endpackage

// File: rtl/vector_ingest_if.sv
// vector_ingest_if: host byte link, vertex stream and query port of the ingest stage
interface vector_ingest_if import vector_ingest_pkg::*; #(parameter int DIM = DEFAULT_DIM);
    logic [7:0] byte_in;
    logic byte_valid_in;
    logic byte_ready_out;
    logic [WORD_W-1:0] vertex_out;
    logic vertex_valid_out;
    logic vertex_ready_in;
    logic vertex_last_out;
    logic [DIM-1:0][WORD_W-1:0] query_out;
    logic query_valid_out;
    logic [7:0] err_count_out;
    modport slave (
        input byte_in, byte_valid_in, vertex_ready_in,
        output byte_ready_out, vertex_out, vertex_valid_out, vertex_last_out,
        output query_out, query_valid_out, err_count_out
    );
    modport master (
        output byte_in, byte_valid_in, vertex_ready_in,
        input byte_ready_out, vertex_out, vertex_valid_out, vertex_last_out,
        input query_out, query_valid_out, err_count_out
    );
endinterface

// File: rtl/vector_ingest.sv
// vector_ingest: frames host byte packets, verifies XOR checksum, routes words to the query port or vertex stream
module vector_ingest import vector_ingest_pkg::*; #(
    parameter int DIM = DEFAULT_DIM,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC
) (
    input logic clk_in,
    input logic rst_in,
    vector_ingest_if.slave bus
);
    localparam int CW = $clog2(DIM * 4);
    localparam int WW = (DIM > 1) ? $clog2(DIM) : 1;
    state_t r_state, w_next;
    logic r_rdy, r_is_query, r_qvalid;
    logic [CW-1:0] r_cnt;
    logic [WW-1:0] r_widx, w_word;
    logic [7:0] r_xor, r_err;
    logic [DIM-1:0][WORD_W-1:0] r_shadow, r_query;
    logic w_take, w_vhs, w_type_ok, w_ck_ok, w_last_byte, w_last_word, w_err, w_commit;
    assign w_take = bus.byte_valid_in & r_rdy;
    assign w_vhs = (r_state == EMIT) & bus.vertex_ready_in;
    assign w_type_ok = (bus.byte_in == TYPE_VERTEX) | (bus.byte_in == TYPE_QUERY);
    assign w_ck_ok = bus.byte_in == r_xor;
    assign w_last_byte = r_cnt == CW'(DIM * 4 - 1);
    assign w_last_word = r_widx == WW'(DIM - 1);
    assign w_word = WW'(r_cnt >> 2);
    assign w_err = w_take & (((r_state == TYPE) & ~w_type_ok) | ((r_state == CHECK) & ~w_ck_ok));
    assign w_commit = w_take & (r_state == CHECK) & w_ck_ok & r_is_query;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_take && bus.byte_in == SYNC_BYTE) ? TYPE : IDLE;
            TYPE:    w_next = w_take ? (w_type_ok ? PAYLOAD : IDLE) : TYPE;
            PAYLOAD: w_next = (w_take && w_last_byte) ? CHECK : PAYLOAD;
            CHECK:   w_next = w_take ? ((w_ck_ok && !r_is_query) ? EMIT : IDLE) : CHECK;
            EMIT:    w_next = (w_vhs && w_last_word) ? IDLE : EMIT;
            default: w_next = IDLE;
        endcase
    end
    // ready is registered so it reads 0 throughout reset and tracks the next state
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= IDLE;
            r_rdy <= 1'b0;
            r_is_query <= 1'b0;
            r_qvalid <= 1'b0;
            r_cnt <= '0;
            r_widx <= '0;
            r_xor <= '0;
            r_err <= '0;
            r_shadow <= '0;
            r_query <= '0;
        end else begin
            r_state <= w_next;
            r_rdy <= w_next != EMIT;
            r_qvalid <= w_commit;
            if (w_err && r_err != 8'hFF) r_err <= r_err + 8'd1;
            if (w_take && r_state == TYPE) begin
                r_is_query <= bus.byte_in == TYPE_QUERY;
                r_xor <= bus.byte_in;
                r_cnt <= '0;
            end
            if (w_take && r_state == PAYLOAD) begin
                r_shadow[w_word][8*r_cnt[1:0] +: 8] <= bus.byte_in;
                r_xor <= r_xor ^ bus.byte_in;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_commit) r_query <= r_shadow;
            if (w_vhs) r_widx <= w_last_word ? '0 : r_widx + 1'b1;
        end
    end
    assign bus.byte_ready_out = r_rdy;
    assign bus.vertex_valid_out = r_state == EMIT;
    assign bus.vertex_out = (r_state == EMIT) ? r_shadow[r_widx] : '0;
    assign bus.vertex_last_out = (r_state == EMIT) & w_last_word;
    assign bus.query_out = r_query;
    assign bus.query_valid_out = r_qvalid;
    assign bus.err_count_out = r_err;
endmodule

// File: tb/tb_vector_ingest.sv
// tb_vector_ingest: directed packet vectors plus backpressure, reset and saturation sequences
module tb_vector_ingest;
    import vector_ingest_pkg::*;
    localparam int DIM = 4;
    typedef logic [0:18][7:0] pkt_t;
    typedef logic [0:23][7:0] buf_t;
    typedef struct {
        int len;
        buf_t b;
        logic exp_pulse;
        logic [DIM-1:0][31:0] exp_q;
        logic [7:0] exp_err;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    int q_pulses = 0;
    int v_cycles = 0;
    vec_t vec [0:5];
    vector_ingest_if #(.DIM(DIM)) bus();
    vector_ingest #(.DIM(DIM), .SYNC_BYTE(8'hA5)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.query_valid_out) q_pulses <= q_pulses + 1;
        if (bus.vertex_valid_out) v_cycles <= v_cycles + 1;
    end
    function automatic pkt_t pkt(input logic [7:0] t, input logic [31:0] w0, w1, w2, w3, input logic [7:0] ck);
        return {8'hA5, t, w0[7:0], w0[15:8], w0[23:16], w0[31:24], w1[7:0], w1[15:8], w1[23:16], w1[31:24],
                w2[7:0], w2[15:8], w2[23:16], w2[31:24], w3[7:0], w3[15:8], w3[23:16], w3[31:24], ck};
    endfunction
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_in = b;
        bus.byte_valid_in = 1'b1;
        while (!bus.byte_ready_out && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 100) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: byte %h not accepted within 100 cycles", b);
        end
        @(posedge clk);
        #1;
        bus.byte_valid_in = 1'b0;
    endtask
    task automatic send_buf(input buf_t b, input int len);
        for (int i = 0; i < len; i++) send(b[i]);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        int snap, vsnap;
        bus.byte_in = 8'h00;
        bus.byte_valid_in = 1'b0;
        bus.vertex_ready_in = 1'b0;
        vec[0] = '{19, {pkt(8'h02, 1, 2, 3, 4, 8'h06), 40'h0}, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1}, 8'd0};
        vec[1] = '{19, {pkt(8'h02, 1, 2, 3, 4, 8'h07), 40'h0}, 1'b0, {32'd4, 32'd3, 32'd2, 32'd1}, 8'd1};
        vec[2] = '{24, {8'h00, 8'hFF, 8'h13, 8'hA5, 8'h07, pkt(8'h02, 5, 6, 7, 8, 8'h0E)}, 1'b1,
                   {32'd8, 32'd7, 32'd6, 32'd5}, 8'd2};
        vec[3] = '{19, {pkt(8'h02, 32'hA5, 0, 0, 0, 8'hA7), 40'h0}, 1'b1, {32'd0, 32'd0, 32'd0, 32'hA5}, 8'd2};
        vec[4] = '{2, {8'hA5, 8'h03, 176'h0}, 1'b0, {32'd0, 32'd0, 32'd0, 32'hA5}, 8'd3};
        vec[5] = '{19, {pkt(8'h02, 32'h11223344, 32'hFFFFFFFF, 32'h80000001, 32'h00A5A500, 8'hC7), 40'h0}, 1'b1,
                   {32'h00A5A500, 32'h80000001, 32'hFFFFFFFF, 32'h11223344}, 8'd3};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 128'(bus.byte_ready_out), 128'd0);
        chk("rst_vvalid", 128'(bus.vertex_valid_out), 128'd0);
        chk("rst_vout", 128'(bus.vertex_out), 128'd0);
        chk("rst_vlast", 128'(bus.vertex_last_out), 128'd0);
        chk("rst_qvalid", 128'(bus.query_valid_out), 128'd0);
        chk("rst_query", 128'(bus.query_out), 128'd0);
        chk("rst_err", 128'(bus.err_count_out), 128'd0);
        rst = 1'b1;
        step();
        chk("ready_after_release", 128'(bus.byte_ready_out), 128'd1);
        for (int i = 0; i < 6; i++) begin
            snap = q_pulses;
            vsnap = v_cycles;
            send_buf(vec[i].b, vec[i].len);
            chk($sformatf("v%0d_qvalid", i), 128'(bus.query_valid_out), 128'(vec[i].exp_pulse));
            chk($sformatf("v%0d_query", i), 128'(bus.query_out), 128'(vec[i].exp_q));
            chk($sformatf("v%0d_err", i), 128'(bus.err_count_out), 128'(vec[i].exp_err));
            step();
            chk($sformatf("v%0d_qvalid_drop", i), 128'(bus.query_valid_out), 128'd0);
            chk($sformatf("v%0d_pulses", i), 128'(q_pulses - snap), 128'(vec[i].exp_pulse));
            chk($sformatf("v%0d_no_vertex", i), 128'(v_cycles - vsnap), 128'd0);
        end
        send_buf({pkt(8'h01, 32'hDEADBEEF, 0, 0, 0, 8'h23), 40'h0}, 19);
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_valid", 128'(bus.vertex_valid_out), 128'd1);
            chk("bp_hold_word", 128'(bus.vertex_out), 128'hDEADBEEF);
            chk("bp_hold_last", 128'(bus.vertex_last_out), 128'd0);
            chk("bp_hold_ready", 128'(bus.byte_ready_out), 128'd0);
            step();
        end
        bus.vertex_ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid", 128'(bus.vertex_valid_out), 128'd1);
            chk("bp_word", 128'(bus.vertex_out), (k == 0) ? 128'hDEADBEEF : 128'd0);
            chk("bp_last", 128'(bus.vertex_last_out), 128'(k == 3));
            chk("bp_ready", 128'(bus.byte_ready_out), 128'd0);
            step();
        end
        chk("bp_done_valid", 128'(bus.vertex_valid_out), 128'd0);
        chk("bp_done_ready", 128'(bus.byte_ready_out), 128'd1);
        chk("bp_query_kept", 128'(bus.query_out), 128'(vec[5].exp_q));
        chk("bp_err", 128'(bus.err_count_out), 128'd3);
        send_buf({pkt(8'h01, 1, 2, 3, 4, 8'h05), 40'h0}, 19);
        for (int k = 0; k < 4; k++) begin
            chk("fr_valid", 128'(bus.vertex_valid_out), 128'd1);
            chk("fr_word", 128'(bus.vertex_out), 128'(k + 1));
            chk("fr_last", 128'(bus.vertex_last_out), 128'(k == 3));
            step();
        end
        chk("fr_done_valid", 128'(bus.vertex_valid_out), 128'd0);
        chk("fr_done_ready", 128'(bus.byte_ready_out), 128'd1);
        bus.vertex_ready_in = 1'b0;
        vsnap = v_cycles;
        send(8'hA5);
        send(8'h01);
        for (int k = 0; k < 8; k++) send(8'h11);
        rst = 1'b0;
        step();
        chk("mid_rst_ready", 128'(bus.byte_ready_out), 128'd0);
        chk("mid_rst_query", 128'(bus.query_out), 128'd0);
        chk("mid_rst_err", 128'(bus.err_count_out), 128'd0);
        rst = 1'b1;
        step();
        chk("mid_rst_release_ready", 128'(bus.byte_ready_out), 128'd1);
        send_buf({pkt(8'h02, 1, 2, 3, 4, 8'h06), 40'h0}, 19);
        chk("mid_rst_qvalid", 128'(bus.query_valid_out), 128'd1);
        chk("mid_rst_commit", 128'(bus.query_out), 128'({32'd4, 32'd3, 32'd2, 32'd1}));
        chk("mid_rst_err_after", 128'(bus.err_count_out), 128'd0);
        repeat (5) step();
        chk("mid_rst_no_vertex", 128'(v_cycles - vsnap), 128'd0);
        for (int k = 0; k < 254; k++) begin
            send(8'hA5);
            send(8'h09);
        end
        chk("sat_254", 128'(bus.err_count_out), 128'd254);
        send(8'hA5);
        send(8'h09);
        chk("sat_255", 128'(bus.err_count_out), 128'd255);
        for (int k = 0; k < 45; k++) begin
            send(8'hA5);
            send(8'h09);
        end
        chk("sat_hold", 128'(bus.err_count_out), 128'd255);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
